// File: rtl/byte_striping.sv
// Byte striper: round-robin distributes a serial byte stream onto four lanes with fill + output buffering.
// Optional feature: define BYTE_STRIPING_PARITY_EN to add the registered per-lane even-parity output Lane_par.
module byte_striping #(
    parameter logic [7:0] PAD_BYTE = 8'hF7
) (
    input  logic       clk250k,
    input  logic       reset_L,
    input  logic [7:0] in,
    input  logic       valid_in,
    output logic       ready_in,
    input  logic       flush,
    output logic [7:0] Lane_0,
    output logic [7:0] Lane_1,
    output logic [7:0] Lane_2,
    output logic [7:0] Lane_3,
    output logic       valid_out,
    input  logic       lane_ready,
`ifdef BYTE_STRIPING_PARITY_EN
    output logic [3:0] Lane_par,
`endif
    output logic [1:0] ctr_3
);

    logic [7:0] fill      [4];
    logic [7:0] lane_q    [4];
    logic [7:0] grp       [4];
    logic [7:0] load_data [4];
    logic       staging;
    logic       accept;
    logic       consume;
    logic       out_free;
    logic       grp_done;
    logic       load_staged;
    logic       load_new;
    logic       stage_new;

    assign ready_in = !staging;
    assign accept   = valid_in && ready_in;
    assign consume  = valid_out && lane_ready;
    assign out_free = !valid_out || consume;

    // A full buffer blocks input, so a new group can only complete while nothing is staged.
    assign grp_done    = !staging &&
                         ((accept && ctr_3 == 2'd3) || (flush && (accept || ctr_3 != 2'd0)));
    assign load_staged = staging && consume;
    assign load_new    = grp_done && out_free;
    assign stage_new   = grp_done && !out_free;

    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            grp[k] = PAD_BYTE;
            if (2'(k) < ctr_3)
                grp[k] = fill[k];
            else if (2'(k) == ctr_3 && accept)
                grp[k] = in;
            load_data[k] = staging ? fill[k] : grp[k];
        end
    end

`ifdef BYTE_STRIPING_PARITY_EN
    logic [3:0] par_next;

    always_comb begin
        for (int k = 0; k < 4; k++)
            par_next[k] = ^load_data[k];
    end
`endif

    // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk250k or negedge reset_L) begin
        if (!reset_L) begin
            // NOTE: the small fill buffer and lanes are reset explicitly; they are registers, not RAM.
            for (int k = 0; k < 4; k++) begin
                fill[k]   <= 8'h00;
                lane_q[k] <= 8'h00;
            end
            staging   <= 1'b0;
            valid_out <= 1'b0;
            ctr_3     <= 2'd0;
`ifdef BYTE_STRIPING_PARITY_EN
            Lane_par  <= 4'b0000;
`endif
        end else begin
            if (load_staged || load_new) begin
                for (int k = 0; k < 4; k++)
                    lane_q[k] <= load_data[k];
                valid_out <= 1'b1;
`ifdef BYTE_STRIPING_PARITY_EN
                Lane_par  <= par_next;
`endif
            end else if (consume) begin
                valid_out <= 1'b0;
            end

            if (load_staged)
                staging <= 1'b0;

            if (stage_new) begin
                for (int k = 0; k < 4; k++)
                    fill[k] <= grp[k];
                staging <= 1'b1;
            end else if (accept && !grp_done) begin
                fill[ctr_3] <= in;
            end

            if (grp_done)
                ctr_3 <= 2'd0;
            else if (accept)
                ctr_3 <= ctr_3 + 2'd1;
        end
    end

    assign Lane_0 = lane_q[0];
    assign Lane_1 = lane_q[1];
    assign Lane_2 = lane_q[2];
    assign Lane_3 = lane_q[3];

endmodule

// File: tb/tb_byte_striping.sv
// Scoreboard bench for byte_striping: expected groups are queued as bytes are accepted and checked on consume.
// Define BYTE_STRIPING_PARITY_EN to also check Lane_par.
module tb_byte_striping;

    localparam logic [7:0] PAD = 8'hF7;

    logic       clk250k = 1'b0;
    logic       reset_L;
    logic [7:0] in;
    logic       valid_in;
    logic       ready_in;
    logic       flush;
    logic [7:0] Lane_0, Lane_1, Lane_2, Lane_3;
    logic       valid_out;
    logic       lane_ready;
    logic [1:0] ctr_3;
`ifdef BYTE_STRIPING_PARITY_EN
    logic [3:0] Lane_par;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  mfill[4];
    int          mctr = 0;

    byte_striping dut (
        .clk250k   (clk250k),
        .reset_L   (reset_L),
        .in        (in),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .flush     (flush),
        .Lane_0    (Lane_0),
        .Lane_1    (Lane_1),
        .Lane_2    (Lane_2),
        .Lane_3    (Lane_3),
        .valid_out (valid_out),
        .lane_ready(lane_ready),
`ifdef BYTE_STRIPING_PARITY_EN
        .Lane_par  (Lane_par),
`endif
        .ctr_3     (ctr_3)
    );

    always #5 clk250k = ~clk250k;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] lanes();
        return {Lane_3, Lane_2, Lane_1, Lane_0};
    endfunction

    task automatic push_group();
        exp_q.push_back({mfill[3], mfill[2], mfill[1], mfill[0]});
        mctr = 0;
    endtask

    task automatic send(input logic [7:0] b, input logic fl);
        logic acc = 1'b0;
        int   budget = 0;
        while (!acc && budget < 50) begin
            @(negedge clk250k);
            check("ctr_3", 32'(ctr_3), 32'(mctr));
            in = b; valid_in = 1'b1; flush = fl;
            acc = ready_in;
            @(posedge clk250k);
            budget++;
        end
        #1 valid_in = 1'b0; flush = 1'b0;
        if (!acc) begin
            check("accept_timeout", 0, 1);
        end else begin
            mfill[mctr] = b;
            if (fl)
                for (int k = mctr + 1; k < 4; k++) mfill[k] = PAD;
            if (mctr == 3 || fl) push_group();
            else mctr++;
        end
    endtask

    task automatic do_flush();
        logic acc;
        @(negedge clk250k);
        flush = 1'b1; valid_in = 1'b0;
        acc = ready_in;
        @(posedge clk250k);
        #1 flush = 1'b0;
        if (acc && mctr != 0) begin
            for (int k = mctr; k < 4; k++) mfill[k] = PAD;
            push_group();
        end
    endtask

    task automatic drain();
        int budget = 0;
        while ((exp_q.size() != 0 || valid_out) && budget < 100) begin
            @(posedge clk250k);
            #1 budget++;
        end
        check("drain", 32'(exp_q.size()), 0);
    endtask

    // Consume monitor: compares every group the sink takes against the scoreboard.
    always @(negedge clk250k) begin
        logic [31:0] e;
        #2;
        if (reset_L && valid_out && lane_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_group", lanes(), 32'hDEAD_0000);
            end else begin
                e = exp_q.pop_front();
                check("group", lanes(), e);
`ifdef BYTE_STRIPING_PARITY_EN
                check("parity", 32'(Lane_par), 32'({^e[31:24], ^e[23:16], ^e[15:8], ^e[7:0]}));
`endif
            end
        end
    end

    initial begin
        reset_L = 1'b0; in = 8'h00; valid_in = 1'b0; flush = 1'b0; lane_ready = 1'b1;
        #3;
        check("rst_lanes", lanes(), 32'h0);
        check("rst_valid_out", 32'(valid_out), 0);
        check("rst_ctr_3", 32'(ctr_3), 0);
        check("rst_ready_in", 32'(ready_in), 1);
        @(negedge clk250k);
        reset_L = 1'b1;

        // Basic group, one-cycle valid pulse
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        check("basic_valid", 32'(valid_out), 1);
        check("basic_lanes", lanes(), 32'h4433_2211);
        check("basic_ctr_wrap", 32'(ctr_3), 0);
        @(posedge clk250k); #1;
        check("basic_valid_drop", 32'(valid_out), 0);

        // Streaming 01..0C
        for (int i = 1; i <= 12; i++) begin
            send(8'(i), 1'b0);
            check("stream_ready", 32'(ready_in), 1);
        end
        drain();

        // Backpressure
        @(negedge clk250k); lane_ready = 1'b0;
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
        check("bp_ready_low", 32'(ready_in), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk250k);
            check("bp_hold_lanes", lanes(), 32'h0403_0201);
            check("bp_hold_valid", 32'(valid_out), 1);
        end
        lane_ready = 1'b1;
        drain();
        check("bp_ready_back", 32'(ready_in), 1);

        // Flush without valid_in
        send(8'hAA, 1'b0); send(8'hBB, 1'b0);
        do_flush();
        check("flush_lanes", lanes(), {PAD, PAD, 16'hBBAA});
        check("flush_ctr", 32'(ctr_3), 0);
        drain();

        // Flush with a byte in the same cycle, then a no-op flush at ctr_3==0
        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b1);
        check("flushv_lanes", lanes(), {PAD, 24'hCC_BBAA});
        do_flush();
        @(posedge clk250k); #1;
        check("flush_noop_valid", 32'(valid_out), 0);
        drain();

        // Flush with the 4th byte: no padding
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b1);
        check("flush_full_lanes", lanes(), 32'h0403_0201);
        drain();

        // Reset mid-group
        send(8'hE1, 1'b0); send(8'hE2, 1'b0);
        @(negedge clk250k); reset_L = 1'b0;
        #2;
        check("midrst_ctr", 32'(ctr_3), 0);
        check("midrst_valid", 32'(valid_out), 0);
        @(negedge clk250k); reset_L = 1'b1;
        mctr = 0;
        send(8'h55, 1'b0); send(8'h66, 1'b0); send(8'h77, 1'b0); send(8'h88, 1'b0);
        check("midrst_lanes", lanes(), 32'h8877_6655);
        drain();

        // Parity pattern
        send(8'h01, 1'b0); send(8'h03, 1'b0); send(8'h07, 1'b0); send(8'h00, 1'b0);
`ifdef BYTE_STRIPING_PARITY_EN
        check("par_pattern", 32'(Lane_par), 32'h5);
`endif
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
